reg_op_sequencer: RTL and testbench

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

---
 rtl/reg_op_pkg.sv | 20 ++
 rtl/alu_32.sv | 25 ++
 rtl/reg_op_sequencer.sv | 116 +++++++++++
 tb/tb_reg_op_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_op_pkg.sv
// Shared types for the register-operation sequencer: opcodes and FSM states.
package reg_op_pkg;

    localparam int OPCODE_W = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        READ_A = 2'b01,
        READ_B = 2'b10,
        WRITE  = 2'b11
    } state_e;

endpackage

// File: rtl/alu_32.sv
// Combinational ALU: ADD/SUB wrap modulo 2^DATA_W, AND/OR are bitwise.
module alu_32
    import reg_op_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    // Select the operation result; truncation to DATA_W gives the modular wrap.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
        endcase
    end

endmodule

// File: rtl/reg_op_sequencer.sv
// Four-state sequencer: accept an instruction, read two operands through a
// single register-file read port, then write the ALU result back.
module reg_op_sequencer
    import reg_op_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    output logic [ADDR_W-1:0] read_register_port_0,
    input  logic [DATA_W-1:0] read_data_port_0,
    output logic [ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    output logic              done
);

    state_e            state_q, state_d;
    op_e               op_q,    op_d;
    logic [ADDR_W-1:0] rd_q,    rd_d;
    logic [ADDR_W-1:0] rs1_q,   rs1_d;
    logic [ADDR_W-1:0] rs2_q,   rs2_d;
    logic [DATA_W-1:0] a_q,     a_d;
    logic [DATA_W-1:0] b_q,     b_d;
    logic [DATA_W-1:0] alu_result;

    alu_32 #(.DATA_W(DATA_W)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    // Next-state and capture logic; instr_* is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d    = op_e'(instr_op);
                    rd_d    = instr_rd;
                    rs1_d   = instr_rs1;
                    rs2_d   = instr_rs2;
                    state_d = READ_A;
                end
            end
            READ_A: begin
                a_d     = read_data_port_0;
                state_d = READ_B;
            end
            READ_B: begin
                b_d     = read_data_port_0;
                state_d = WRITE;
            end
            WRITE: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Output decode from the current state; write strobes are squashed by reset.
    always_comb begin
        instr_ready          = 1'b0;
        read_register_port_0 = '0;
        write_register       = '0;
        write_data           = '0;
        write_enable         = 1'b0;
        done                 = 1'b0;
        case (state_q)
            IDLE:   instr_ready          = 1'b1;
            READ_A: read_register_port_0 = rs1_q;
            READ_B: read_register_port_0 = rs2_q;
            WRITE: begin
                write_register = rd_q;
                write_data     = alu_result;
                // NOTE: reset is synchronous, so the strobe is gated by rst_n directly to block a write in the reset cycle.
                write_enable   = rst_n;
                done           = rst_n;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed self-checking bench for reg_op_sequencer with a bench-owned register file.
module tb_reg_op_sequencer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst_n;
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        instr_op;
    logic [ADDR_W-1:0] instr_rd;
    logic [ADDR_W-1:0] instr_rs1;
    logic [ADDR_W-1:0] instr_rs2;
    logic [ADDR_W-1:0] read_register_port_0;
    logic [DATA_W-1:0] read_data_port_0;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] write_data;
    logic              write_enable;
    logic              done;

    logic [DATA_W-1:0] rf [4];
    int                checks;
    int                failures;
    int                writes;

    reg_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .instr_valid          (instr_valid),
        .instr_ready          (instr_ready),
        .instr_op             (instr_op),
        .instr_rd             (instr_rd),
        .instr_rs1            (instr_rs1),
        .instr_rs2            (instr_rs2),
        .read_register_port_0 (read_register_port_0),
        .read_data_port_0     (read_data_port_0),
        .write_register       (write_register),
        .write_data           (write_data),
        .write_enable         (write_enable),
        .done                 (done)
    );

    assign read_data_port_0 = rf[read_register_port_0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: the register file takes the write that is visible before the edge.
    task automatic step();
        logic              we_s;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        we_s = write_enable;
        wa   = write_register;
        wd   = write_data;
        @(posedge clk);
        if (we_s) begin
            rf[wa] = wd;
            writes++;
        end
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [1:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2,
                             input logic [31:0] exp);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        check({tag, ".ready"}, instr_ready, 1);
        step();
        instr_valid = 1'b0;
        check({tag, ".ra_addr"}, read_register_port_0, rs1);
        check({tag, ".ra_we"}, write_enable, 0);
        step();
        check({tag, ".rb_addr"}, read_register_port_0, rs2);
        check({tag, ".rb_we"}, write_enable, 0);
        step();
        check({tag, ".wr_we"}, write_enable, 1);
        check({tag, ".wr_done"}, done, 1);
        check({tag, ".wr_reg"}, write_register, rd);
        check({tag, ".wr_data"}, write_data, exp);
        check({tag, ".wr_raddr"}, read_register_port_0, 0);
        step();
        check({tag, ".rf"}, rf[rd], exp);
        check({tag, ".idle_ready"}, instr_ready, 1);
        check({tag, ".idle_we"}, write_enable, 0);
    endtask

    logic [1:0] hs_op  [3] = '{2'b00, 2'b11, 2'b01};
    logic [1:0] hs_rd  [3] = '{2'd0, 2'd1, 2'd2};
    logic [1:0] hs_rs1 [3] = '{2'd1, 2'd0, 2'd3};
    logic [1:0] hs_rs2 [3] = '{2'd2, 2'd3, 2'd1};

    initial begin
        checks      = 0;
        failures    = 0;
        writes      = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = 2'b00;
        instr_rd    = '0;
        instr_rs1   = '0;
        instr_rs2   = '0;
        rf[0] = 32'd0; rf[1] = 32'd5; rf[2] = 32'd7; rf[3] = 32'd0;
        #1;

        // Reset state
        step();
        step();
        check("rst.we_low", write_enable, 0);
        check("rst.done_low", done, 0);
        rst_n = 1'b1;
        check("rst.ready", instr_ready, 1);
        check("rst.wreg", write_register, 0);
        check("rst.wdata", write_data, 0);
        check("rst.raddr", read_register_port_0, 0);
        step();
        check("rst.idle_hold", instr_ready, 1);

        // ADD r3 = r1 + r2
        run_instr("add", 2'b00, 2'd3, 2'd1, 2'd2, 32'd12);

        // SUB wrap r0 = r0 - r1
        rf[0] = 32'd0; rf[1] = 32'd1;
        run_instr("sub", 2'b01, 2'd0, 2'd0, 2'd1, 32'hFFFF_FFFF);

        // AND / OR
        rf[2] = 32'hF0F0_F0F0; rf[3] = 32'h0FF0_0FF0;
        run_instr("and", 2'b10, 2'd1, 2'd2, 2'd3, 32'h00F0_00F0);
        run_instr("or",  2'b11, 2'd1, 2'd2, 2'd3, 32'hFFF0_FFF0);

        // Aliasing: r1 = r1 + r1
        rf[1] = 32'd9;
        run_instr("alias", 2'b00, 2'd1, 2'd1, 2'd1, 32'd18);

        // Handshake with instr_valid held high and garbage between acceptances
        rf[0] = 32'd10; rf[1] = 32'd20; rf[2] = 32'd30; rf[3] = 32'd40;
        writes      = 0;
        instr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k % 4 == 0) begin
                instr_op  = hs_op[k/4];
                instr_rd  = hs_rd[k/4];
                instr_rs1 = hs_rs1[k/4];
                instr_rs2 = hs_rs2[k/4];
            end else begin
                instr_op  = 2'b01;
                instr_rd  = 2'd3;
                instr_rs1 = 2'd3;
                instr_rs2 = 2'd3;
            end
            check($sformatf("hs.ready%0d", k), instr_ready, (k % 4 == 0) ? 1 : 0);
            step();
        end
        instr_valid = 1'b0;
        check("hs.writes", writes, 3);
        check("hs.r0", rf[0], 32'd50);
        check("hs.r1", rf[1], 32'd58);
        check("hs.r2", rf[2], 32'hFFFF_FFEE);
        check("hs.r3", rf[3], 32'd40);

        // Reset asserted in WRITE abandons the instruction
        writes      = 0;
        instr_valid = 1'b1;
        instr_op    = 2'b00;
        instr_rd    = 2'd3;
        instr_rs1   = 2'd0;
        instr_rs2   = 2'd0;
        check("mr.ready", instr_ready, 1);
        step();
        instr_valid = 1'b0;
        step();
        step();
        check("mr.in_write", write_register, 3);
        rst_n = 1'b0;
        #1;
        check("mr.we_gated", write_enable, 0);
        check("mr.done_gated", done, 0);
        step();
        rst_n = 1'b1;
        check("mr.ready_after", instr_ready, 1);
        check("mr.we_after", write_enable, 0);
        check("mr.r3_kept", rf[3], 32'd40);
        check("mr.no_write", writes, 0);
        step();
        check("mr.idle_hold", instr_ready, 1);
        check("mr.no_write2", writes, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
